// File: rtl/uart_pkg.sv
// Shared UART definitions: timing constants, parity modes,
// frame FSM states and a parity helper for the tx/rx pair.
package uart_pkg;

  // 50 MHz / 115200 baud, rounded to the nearest cycle.
  localparam int CLKS_PER_BIT_50M_115200 = 434;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  // Even parity is the XOR of all data bits;
  // odd parity is its inverse.
  function automatic logic parity_of(
    input logic [7:0] d,
    input int         mode
  );
    logic p;
    p = ^d;
    unique case (1'b1)
      (mode == PAR_ODD): return ~p;
      default:           return p;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART pair.
// Ports: clk_50M, reset (sync, high), restart (hold count at 0),
//   bit_tick (last cycle of a bit), pre_tick (one cycle earlier).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_115200
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic restart,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk_50M) begin
    if (reset || restart) begin
      count <= '0;
    end else if (bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_tick = (count == CW'(CLKS_PER_BIT - 1));
  // Lets a registered consumer line up with the final bit cycle.
  assign pre_tick = (count == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, optional parity, stop.
// Ports: clk_50M, reset (sync, high), tx_data/tx_valid/tx_ready byte
//   handshake into a one-entry holding register, tx serial line,
//   tx_busy (frame in progress), tx_done (last stop-bit cycle pulse).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_115200,
  parameter int PARITY       = PAR_NONE
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  uart_state_t state, state_n;

  logic [7:0] shift, shift_n;
  logic [7:0] hold, hold_n;
  logic       hold_full, hold_full_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       par, par_n;
  logic       tx_n;
  logic       busy_n;
  logic       done_n;
  logic       accept;
  logic       load;
  logic       bit_tick;
  logic       pre_tick;

  // Counter is parked at 0 in IDLE so the first
  // bit after a load gets a full period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_50M (clk_50M),
    .reset   (reset),
    .restart (state == S_IDLE),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state     <= S_IDLE;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      tx        <= 1'b1;
      tx_ready  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      bit_cnt   <= bit_cnt_n;
      par       <= par_n;
      tx        <= tx_n;
      tx_ready  <= !hold_full_n;
      tx_busy   <= busy_n;
      tx_done   <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    hold_n    = hold;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    tx_n      = tx;
    done_n    = 1'b0;
    load      = 1'b0;
    accept    = tx_valid && tx_ready;

    unique case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        load = hold_full;
      end
      S_START: begin
        if (bit_tick) begin
          state_n   = S_DATA;
          tx_n      = shift[7];
          bit_cnt_n = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_cnt == 3'd7) begin
            state_n = HAS_PAR ? S_PARITY : S_STOP;
            tx_n    = HAS_PAR ? par : 1'b1;
          end else begin
            shift_n   = {shift[6:0], 1'b0};
            tx_n      = shift[6];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        done_n = pre_tick;
        if (bit_tick) begin
          if (hold_full) begin
            // Chain straight into the next start bit.
            load = 1'b1;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (load) begin
      shift_n   = hold;
      par_n     = parity_of(hold, PARITY);
      bit_cnt_n = '0;
      state_n   = S_START;
      tx_n      = 1'b0;
    end

    // A same-edge accept refills the slot being emptied.
    if (accept) begin
      hold_n      = tx_data;
      hold_full_n = 1'b1;
    end else if (load) begin
      hold_full_n = 1'b0;
    end else begin
      hold_full_n = hold_full;
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no/even/odd
// parity) against a frame-level waveform model and a serial receiver.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BIT = CLKS_PER_BIT_50M_115200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [3];
  logic [2:0] vin;
  logic [2:0] txo;
  logic [2:0] rdy;
  logic [2:0] busy;
  logic [2:0] done;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(BIT), .PARITY(PAR_NONE)) u0 (
    .clk_50M(clk), .reset(rst), .tx_data(din[0]),
    .tx_valid(vin[0]), .tx_ready(rdy[0]), .tx(txo[0]),
    .tx_busy(busy[0]), .tx_done(done[0])
  );
  uart_tx #(.CLKS_PER_BIT(BIT), .PARITY(PAR_EVEN)) u1 (
    .clk_50M(clk), .reset(rst), .tx_data(din[1]),
    .tx_valid(vin[1]), .tx_ready(rdy[1]), .tx(txo[1]),
    .tx_busy(busy[1]), .tx_done(done[1])
  );
  uart_tx #(.CLKS_PER_BIT(BIT), .PARITY(PAR_ODD)) u2 (
    .clk_50M(clk), .reset(rst), .tx_data(din[2]),
    .tx_valid(vin[2]), .tx_ready(rdy[2]), .tx(txo[2]),
    .tx_busy(busy[2]), .tx_done(done[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Level of frame bit k: start, data MSB first, parity, stop.
  function automatic logic exp_bit(input logic [7:0] b,
                                   input int k, input int pm);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[8-k];
    if (k == 9 && pm != PAR_NONE)
      return (($countones(b) % 2) == 1) ^ (pm == PAR_ODD);
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input int s, input logic [7:0] b);
    int n;
    n = 0;
    din[s] = b;
    vin[s] = 1'b1;
    while (rdy[s] !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("send_wait_s%0d", s), 32'(n < 20000), 1);
    @(negedge clk);
    vin[s] = 1'b0;
    din[s] = 8'($urandom);
  endtask

  // First negedge awaited is the first start-bit cycle.
  task automatic watch(input int s, input int pm,
                       input logic [7:0] q[$]);
    int  nb, dn;
    bit  dpos, bz, ok;
    logic want;
    nb   = (pm == PAR_NONE) ? 10 : 11;
    dn   = 0;
    dpos = 1'b1;
    bz   = 1'b1;
    for (int k = 0; k < q.size() * nb; k++) begin
      want = exp_bit(q[k/nb], k % nb, pm);
      ok   = 1'b1;
      for (int j = 0; j < BIT; j++) begin
        @(negedge clk);
        if (txo[s] !== want) ok = 1'b0;
        if (busy[s] !== 1'b1) bz = 1'b0;
        if (done[s] === 1'b1) begin
          dn++;
          if (k % nb != nb - 1 || j != BIT - 1) dpos = 1'b0;
        end
      end
      chk($sformatf("s%0d_bit%0d", s, k), 32'(ok), 1);
    end
    chk($sformatf("s%0d_done_cnt", s), dn, q.size());
    chk($sformatf("s%0d_done_pos", s), 32'(dpos), 1);
    chk($sformatf("s%0d_busy", s), 32'(bz), 1);
  endtask

  // Idle check over n cycles on instance s.
  task automatic idle_chk(input string tag, input int s, input int n);
    bit hi, nb, nd;
    hi = 1'b1; nb = 1'b1; nd = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (txo[s] !== 1'b1) hi = 1'b0;
      if (busy[s] !== 1'b0) nb = 1'b0;
      if (done[s] !== 1'b0) nd = 1'b0;
    end
    chk({tag, "_tx_high"}, 32'(hi), 1);
    chk({tag, "_not_busy"}, 32'(nb), 1);
    chk({tag, "_no_done"}, 32'(nd), 1);
  endtask

  // Behavioural receiver: mid-bit sampling, MSB first.
  task automatic rx_frames(input logic [7:0] q[$], output int got);
    int w;
    logic [7:0] b;
    got = 0;
    for (int f = 0; f < q.size(); f++) begin
      w = 0;
      while (txo[0] !== 1'b0 && w < 10000) begin
        @(negedge clk);
        w++;
      end
      chk("rx_start_seen", 32'(w < 10000), 1);
      repeat (BIT / 2) @(negedge clk);
      chk("rx_start_mid", 32'(txo[0]), 0);
      b = '0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b = {b[6:0], txo[0]};
      end
      repeat (BIT) @(negedge clk);
      chk("rx_stop", 32'(txo[0]), 1);
      chk($sformatf("rx_msg%0d", f), b, q[f]);
      got++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] qa[$];
    logic [7:0] qp[$];
    logic [7:0] qc[$];
    logic [7:0] qr[$];
    logic [7:0] qz[$];
    int got;

    rst = 1'b1;
    vin = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_tx", 32'(txo), 3'b111);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy), 3'b111);
    idle_chk("idle", 0, 1000);

    // Single frames: 0xA5 plain, 0x07 with even and odd parity.
    qa.push_back(8'hA5);
    qp.push_back(8'h07);
    fork
      send(0, 8'hA5);
      send(1, 8'h07);
      send(2, 8'h07);
    join
    fork
      watch(0, PAR_NONE, qa);
      watch(1, PAR_EVEN, qp);
      watch(2, PAR_ODD, qp);
    join
    @(negedge clk);
    chk("a5_busy_fall", 32'(busy[0]), 0);
    chk("a5_tx_idle", 32'(txo[0]), 1);
    repeat (400) @(negedge clk);
    chk("par_busy_fall", 32'(busy[2:1]), 0);

    // Back-to-back frames with the producer always ready.
    qc.push_back(8'h3C);
    qc.push_back(8'hFF);
    qc.push_back(8'h00);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          send(0, qc[i]);
          chk($sformatf("ready_drop%0d", i), 32'(rdy[0]), 0);
        end
      end
      begin
        @(negedge clk);
        watch(0, PAR_NONE, qc);
      end
    join
    @(negedge clk);
    chk("b2b_busy_fall", 32'(busy[0]), 0);

    // Random bytes through the serial receiver.
    for (int i = 0; i < 10; i++) qr.push_back(8'($urandom));
    fork
      begin
        for (int i = 0; i < 10; i++) send(0, qr[i]);
      end
      rx_frames(qr, got);
    join
    chk("rx_complete", got, 10);
    repeat (300) @(negedge clk);

    // Reset mid-frame with a byte held.
    send(0, 8'h5A);
    send(0, 8'hC3);
    chk("held_not_ready", 32'(rdy[0]), 0);
    repeat (1998) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(txo[0]), 1);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_done", 32'(done[0]), 0);
    chk("abort_ready", 32'(rdy[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", 32'(rdy[0]), 1);
    idle_chk("post_abort", 0, 1000);
    qz.push_back(8'h96);
    send(0, 8'h96);
    watch(0, PAR_NONE, qz);
    @(negedge clk);
    chk("final_busy_fall", 32'(busy[0]), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
